alu_md_control: RTL and testbench

Execute-stage ALU control for the pipelined RISC-V core, extended with RV32M/RV64M multiply/divide sequencing. It keeps the single-cycle ALUop decode for base instructions. M-extension ops are routed to an iterative multiply/divide datapath, and the block raises a stall request to the hazard unit until the result is ready. It sits between ID/EX decode flags and the EX/MEM result mux.

---
 rtl/alu_md_control_pkg.sv | 40 ++++
 rtl/alu_md_control_if.sv | 44 ++++
 rtl/md_iter_unit.sv | 102 ++++++++++
 rtl/alu_md_control.sv | 121 ++++++++++++
 tb/tb_alu_md_control.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_md_control_pkg.sv
// alu_md_control shared definitions
// ALUop codes, M-extension func codes, FSM states
package alu_md_control_pkg;

  localparam logic [3:0] ALUOP_LS   = 4'b0000;
  localparam logic [3:0] ALUOP_NONE = 4'b1111;

  localparam logic [6:0] M_FUNC7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_t;

  function automatic logic signed_a(
    input logic [2:0] f3
  );
    return (f3 == F3_MULH) || (f3 == F3_MULHSU)
        || (f3 == F3_DIV)  || (f3 == F3_REM);
  endfunction

  function automatic logic signed_b(
    input logic [2:0] f3
  );
    return (f3 == F3_MULH) || (f3 == F3_DIV)
        || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/alu_md_control_if.sv
// alu_md_control ID/EX-side bundle
// master = pipeline, slave = alu_md_control
interface alu_md_control_if #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
);
  logic               valid_in;
  logic               flush;
  logic               I_type;
  logic               L_type;
  logic               S_type;
  logic               R_type;
  logic               B_type;
  logic               JALR_instr;
  logic [2:0]         func3;
  logic [6:0]         func7;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic [ALUOP_W-1:0] ALUop;
  logic               ALUdata_flag;
  logic [XLEN-1:0]    md_result;
  logic               md_done;
  logic               stall_req;

  modport master (
    output valid_in, flush,
    output I_type, L_type, S_type,
    output R_type, B_type, JALR_instr,
    output func3, func7,
    output rs1_val, rs2_val,
    input  ALUop, ALUdata_flag,
    input  md_result, md_done, stall_req
  );

  modport slave (
    input  valid_in, flush,
    input  I_type, L_type, S_type,
    input  R_type, B_type, JALR_instr,
    input  func3, func7,
    input  rs1_val, rs2_val,
    output ALUop, ALUdata_flag,
    output md_result, md_done, stall_req
  );
endinterface

// File: rtl/md_iter_unit.sv
// Radix-2 shift-add multiplier / restoring divider
// sharing one 2*XLEN accumulator, with sign fix-up
module md_iter_unit
  import alu_md_control_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            special,
  input  logic            step,
  input  logic            last,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] md_result
);
  localparam int W2 = 2 * XLEN;

  logic [W2-1:0]   acc_q, acc_d, prod;
  logic [XLEN-1:0] dvs_q, ma, mb;
  logic [XLEN-1:0] q, r, iter_res, spec_res;
  logic [XLEN:0]   sum, hi_ext, trial;
  logic [2:0]      f3_q;
  logic            neg_q, rneg_q, sa, sb;

  // Operand magnitudes and special-case result
  always_comb begin
    sa = signed_a(func3) & a[XLEN-1];
    sb = signed_b(func3) & b[XLEN-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    if (b == '0)
      spec_res = func3[1] ? a : '1;
    else
      spec_res = func3[1] ? '0 : a;
  end

  // One iteration; hi_ext keeps the bit
  // shifted out of the remainder half
  always_comb begin
    sum = {1'b0, acc_q[W2-1:XLEN]}
        + (acc_q[0] ? {1'b0, dvs_q} : '0);
    hi_ext = acc_q[W2-1:XLEN-1];
    trial = hi_ext - {1'b0, dvs_q};
    if (!f3_q[2])
      acc_d = {sum, acc_q[XLEN-1:1]};
    else if (!trial[XLEN])
      acc_d = {trial[XLEN-1:0],
               acc_q[XLEN-2:0], 1'b1};
    else
      acc_d = {hi_ext[XLEN-1:0],
               acc_q[XLEN-2:0], 1'b0};
  end

  // Sign fix-up of the final iteration value
  always_comb begin
    prod = neg_q ? -acc_d : acc_d;
    q = acc_d[XLEN-1:0];
    r = acc_d[W2-1:XLEN];
    if (!f3_q[2])
      iter_res = (f3_q[1:0] == 2'b00)
               ? prod[XLEN-1:0]
               : prod[W2-1:XLEN];
    else if (!f3_q[1])
      iter_res = neg_q ? -q : q;
    else
      iter_res = rneg_q ? -r : r;
  end

  // Operand latch and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      dvs_q  <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else if (load) begin
      acc_q  <= {{XLEN{1'b0}},
                 func3[2] ? ma : mb};
      dvs_q  <= func3[2] ? mb : ma;
      f3_q   <= func3;
      neg_q  <= sa ^ sb;
      rneg_q <= sa;
    end else if (step) begin
      acc_q <= acc_d;
    end
  end

  // Result register, updated only on completion
  always_ff @(posedge clk) begin
    if (rst)
      md_result <= '0;
    else if (load && special)
      md_result <= spec_res;
    else if (step && last)
      md_result <= iter_res;
  end

endmodule

// File: rtl/alu_md_control.sv
// EX-stage ALU control with iterative M-ext
// sequencing and hazard-unit stall request
module alu_md_control
  import alu_md_control_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1,
  parameter int ALUOP_W  = 4
) (
  input logic             clk,
  input logic             rst,
  alu_md_control_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  md_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    op;
  logic          is_md, start, special;
  logic          busy, step, last;

  assign is_md = (ENABLE_M != 0) && bus.R_type
              && (bus.func7 == M_FUNC7);

  // Base ALUop decode; M ops park the ALU
  always_comb begin
    op = ALUOP_NONE;
    priority case (1'b1)
      bus.R_type:
        op = {bus.func7[5], bus.func3};
      bus.I_type:
        op = {(bus.func3 == 3'b101)
              & bus.func7[5], bus.func3};
      bus.B_type:
        op = {3'b001,
              bus.func3[2] & bus.func3[1]};
      bus.L_type, bus.S_type:
        op = ALUOP_LS;
      bus.JALR_instr:
        op = {1'b0, bus.func3};
      default:
        op = ALUOP_NONE;
    endcase
    if (is_md)
      op = ALUOP_NONE;
  end

  assign bus.ALUop = ALUOP_W'(op);
  assign bus.ALUdata_flag = bus.R_type
                          | bus.B_type;

  assign special = bus.func3[2] && (
    (bus.rs2_val == '0) ||
    (!bus.func3[0] &&
     (bus.rs1_val == (XLEN'(1) << (XLEN-1))) &&
     (bus.rs2_val == '1)));

  assign start = (state_q == ST_IDLE)
              && bus.valid_in && is_md
              && !bus.flush;
  assign busy = (state_q == ST_MUL)
             || (state_q == ST_DIV);
  assign step = busy && !bus.flush;
  assign last = (cnt_q == CW'(XLEN-1));

  assign bus.stall_req = start | step;
  assign bus.md_done = (state_q == ST_DONE);

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start) begin
          if (!bus.func3[2])
            state_d = ST_MUL;
          else if (special)
            state_d = ST_DONE;
          else
            state_d = ST_DIV;
        end
      ST_MUL, ST_DIV:
        if (bus.flush)
          state_d = ST_IDLE;
        else if (last)
          state_d = ST_DONE;
      ST_DONE:
        state_d = ST_IDLE;
    endcase
  end

  // State register and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start)
        cnt_q <= '0;
      else if (step)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  md_iter_unit #(
    .XLEN(XLEN)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .special  (special),
    .step     (step),
    .last     (last),
    .func3    (bus.func3),
    .a        (bus.rs1_val),
    .b        (bus.rs2_val),
    .md_result(bus.md_result)
  );

endmodule

// File: tb/tb_alu_md_control.sv
// Directed self-checking bench for alu_md_control
// Hand-computed expectations, immediate assertions
module tb_alu_md_control;
  import alu_md_control_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  alu_md_control_if #(
    .XLEN(32), .ALUOP_W(4)
  ) bus ();

  alu_md_control #(
    .XLEN(32), .ENABLE_M(1), .ALUOP_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_in;
    bus.valid_in   = 1'b0;
    bus.flush      = 1'b0;
    bus.I_type     = 1'b0;
    bus.L_type     = 1'b0;
    bus.S_type     = 1'b0;
    bus.R_type     = 1'b0;
    bus.B_type     = 1'b0;
    bus.JALR_instr = 1'b0;
    bus.func3      = 3'b000;
    bus.func7      = 7'b0000000;
    bus.rs1_val    = 32'h0;
    bus.rs2_val    = 32'h0;
  endtask

  task automatic decode(
    input string      tag,
    input logic [5:0] rilsbj,
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic [3:0] exp_op,
    input logic       exp_flag
  );
    @(posedge clk); #1;
    clear_in();
    {bus.R_type, bus.I_type, bus.L_type,
     bus.S_type, bus.B_type,
     bus.JALR_instr} = rilsbj;
    bus.func3 = f3;
    bus.func7 = f7;
    @(negedge clk);
    chk({tag, "_op"}, 64'(bus.ALUop), 64'(exp_op));
    chk({tag, "_flag"}, 64'(bus.ALUdata_flag),
        64'(exp_flag));
    chk({tag, "_stall"}, 64'(bus.stall_req), 64'd0);
  endtask

  task automatic run_md(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          lat,
    input logic [31:0] exp
  );
    int   cyc;
    int   stalls;
    logic got;
    @(posedge clk); #1;
    clear_in();
    bus.R_type   = 1'b1;
    bus.func7    = M_FUNC7;
    bus.func3    = f3;
    bus.rs1_val  = a;
    bus.rs2_val  = b;
    bus.valid_in = 1'b1;
    @(negedge clk);
    stalls = bus.stall_req ? 1 : 0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus.valid_in = (cyc == 3);
      bus.rs1_val  = ~a;
      bus.rs2_val  = a ^ b ^ 32'h5a5a5a5a;
      @(negedge clk);
      if (bus.md_done)
        got = 1'b1;
      else if (bus.stall_req)
        stalls++;
    end
    bus.valid_in = 1'b0;
    chk({tag, "_done"}, 64'(got), 64'd1);
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_stalls"}, 64'(stalls), 64'(lat));
    chk({tag, "_donestall"},
        64'(bus.stall_req), 64'd0);
    chk({tag, "_res"}, 64'(bus.md_result),
        64'(exp));
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res", 64'(bus.md_result), 64'd0);
    chk("rst_done", 64'(bus.md_done), 64'd0);
    chk("rst_stall", 64'(bus.stall_req), 64'd0);
    chk("rst_op", 64'(bus.ALUop), 64'hf);

    decode("r_sub", 6'b100000, 3'b000,
           7'b0100000, 4'b1000, 1'b1);
    decode("i_sra", 6'b010000, 3'b101,
           7'b0100000, 4'b1101, 1'b0);
    decode("i_sll", 6'b010000, 3'b001,
           7'b0100000, 4'b0001, 1'b0);
    decode("b_ltu", 6'b000010, 3'b110,
           7'b0000000, 4'b0011, 1'b1);
    decode("b_lt", 6'b000010, 3'b100,
           7'b0000000, 4'b0010, 1'b1);
    decode("load", 6'b001000, 3'b010,
           7'b0000000, 4'b0000, 1'b0);
    decode("store", 6'b000100, 3'b010,
           7'b0000000, 4'b0000, 1'b0);
    decode("jalr", 6'b000001, 3'b010,
           7'b0000000, 4'b0010, 1'b0);
    decode("none", 6'b000000, 3'b010,
           7'b0100000, 4'b1111, 1'b0);
    decode("r_over_i", 6'b110000, 3'b101,
           7'b0000000, 4'b0101, 1'b1);
    decode("m_park", 6'b100000, 3'b000,
           7'b0000001, 4'b1111, 1'b1);

    run_md("mul", F3_MUL, 32'd7,
           32'hFFFFFFFD, 33, 32'hFFFFFFEB);
    run_md("mulhu", F3_MULHU, 32'hFFFFFFFF,
           32'hFFFFFFFF, 33, 32'hFFFFFFFE);
    run_md("mulh", F3_MULH, 32'hFFFFFFFF,
           32'hFFFFFFFF, 33, 32'h00000000);
    run_md("mulhsu", F3_MULHSU, 32'hFFFFFFFF,
           32'hFFFFFFFF, 33, 32'hFFFFFFFF);
    run_md("div", F3_DIV, 32'hFFFFFFF9,
           32'd2, 33, 32'hFFFFFFFD);
    run_md("rem", F3_REM, 32'hFFFFFFF9,
           32'd2, 33, 32'hFFFFFFFF);
    run_md("divu", F3_DIVU, 32'd100,
           32'd7, 33, 32'd14);
    run_md("remu", F3_REMU, 32'd100,
           32'd7, 33, 32'd2);
    run_md("divu0", F3_DIVU, 32'd5,
           32'd0, 1, 32'hFFFFFFFF);
    run_md("remu0", F3_REMU, 32'd5,
           32'd0, 1, 32'd5);
    run_md("div0", F3_DIV, 32'd5,
           32'd0, 1, 32'hFFFFFFFF);
    run_md("rem0", F3_REM, 32'hFFFFFFFB,
           32'd0, 1, 32'hFFFFFFFB);
    run_md("divovf", F3_DIV, 32'h80000000,
           32'hFFFFFFFF, 1, 32'h80000000);
    run_md("removf", F3_REM, 32'h80000000,
           32'hFFFFFFFF, 1, 32'h00000000);
    run_md("divu_big", F3_DIVU, 32'hFFFFFFFF,
           32'd1, 33, 32'hFFFFFFFF);
    run_md("remu_big", F3_REMU, 32'hFFFFFFFE,
           32'hFFFFFFFF, 33, 32'hFFFFFFFE);

    // flush at T+10 of a DIVU
    @(posedge clk); #1;
    clear_in();
    bus.R_type   = 1'b1;
    bus.func7    = M_FUNC7;
    bus.func3    = F3_DIVU;
    bus.rs1_val  = 32'd100;
    bus.rs2_val  = 32'd7;
    bus.valid_in = 1'b1;
    @(negedge clk);
    chk("fl_start", 64'(bus.stall_req), 64'd1);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
    end
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_stall", 64'(bus.stall_req), 64'd0);
    chk("fl_done", 64'(bus.md_done), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("fl_idle_stall",
        64'(bus.stall_req), 64'd0);
    chk("fl_idle_done", 64'(bus.md_done), 64'd0);
    chk("fl_hold", 64'(bus.md_result),
        64'hFFFFFFFE);
    run_md("fl_mul", F3_MUL, 32'd6,
           32'd7, 33, 32'd42);

    // reset at T+5 of a MUL
    @(posedge clk); #1;
    clear_in();
    bus.R_type   = 1'b1;
    bus.func7    = M_FUNC7;
    bus.func3    = F3_MUL;
    bus.rs1_val  = 32'd5;
    bus.rs2_val  = 32'd5;
    bus.valid_in = 1'b1;
    @(negedge clk);
    chk("rs_start", 64'(bus.stall_req), 64'd1);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rs_busy", 64'(bus.stall_req), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rs_res", 64'(bus.md_result), 64'd0);
    chk("rs_done", 64'(bus.md_done), 64'd0);
    chk("rs_stall", 64'(bus.stall_req), 64'd0);
    run_md("rs_mul", F3_MUL, 32'd3,
           32'd4, 33, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
